// File: rtl/lcd_drive_ctrl_mp.sv
// LCD timing generator with an AHB register file: streams N_PIX pixels/clk from a frame buffer,
// applies saturating brightness, and supports shadowed timing, free-running frames and a frame-done IRQ.
module lcd_drive_ctrl_mp #(
    parameter int W_ADDR     = 32,
    parameter int W_DATA     = 32,
    parameter int IMG_PIX_W  = 8,
    parameter int N_PIX      = 2,
    parameter int W_SIZE     = 12,
    parameter int W_DELAY    = 12,
    parameter int W_FB_ADDR  = 20,
    parameter int DEF_WIDTH  = 768,
    parameter int DEF_HEIGHT = 512
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         sl_HSEL,
    input  logic                         sl_HREADY,
    input  logic [1:0]                   sl_HTRANS,
    input  logic [W_ADDR-1:0]            sl_HADDR,
    input  logic                         sl_HWRITE,
    input  logic [W_DATA-1:0]            sl_HWDATA,
    output logic                         out_sl_HREADY,
    output logic [1:0]                   out_sl_HRESP,
    output logic [W_DATA-1:0]            out_sl_HRDATA,
    output logic                         fb_rd_en,
    output logic [W_FB_ADDR-1:0]         fb_rd_addr,
    input  logic [N_PIX*24-1:0]          fb_rd_data,
    output logic                         out_vsync,
    output logic                         out_hsync,
    output logic                         out_valid,
    output logic [N_PIX*3*IMG_PIX_W-1:0] out_data,
    output logic                         out_irq
);
    localparam int N_COMP = N_PIX * 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_HSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                      r_state;
    logic [W_SIZE-1:0]           r_width, r_height, r_sh_width, r_sh_height, r_col, r_row;
    logic [W_DELAY-1:0]          r_vdly, r_hdly, r_gap, r_sh_vdly, r_sh_hdly, r_sh_gap, r_cnt;
    logic [3:0]                  r_ctrl;
    logic [IMG_PIX_W-1:0]        r_br, r_sh_br;
    logic                        r_sh_mode, r_irq_pend;
    logic [15:0]                 r_frame_cnt;
    logic [W_FB_ADDR-1:0]        r_fb_addr;
    logic [3:0]                  r_ahb_idx;
    logic                        r_ahb_wr, r_ahb_rd;
    logic [2:0]                  r_flags_d1, r_flags_d2;
    logic [N_COMP*IMG_PIX_W-1:0] r_out_data;

    logic                        w_ahb_sel, w_go_vsync, w_line_end, w_last_row, w_frame_end;
    logic [W_SIZE:0]             w_col_next;
    logic [N_COMP*IMG_PIX_W-1:0] w_adj;
    logic [W_DATA-1:0]           w_rdata;
    logic                        w_unused;

    function automatic logic [IMG_PIX_W-1:0] adj_comp(input logic [IMG_PIX_W-1:0] c,
                                                      input logic mode,
                                                      input logic [IMG_PIX_W-1:0] br);
        logic [IMG_PIX_W:0] sum;
        logic [IMG_PIX_W:0] dif;
        sum = {1'b0, c} + {1'b0, br};
        dif = {1'b0, c} - {1'b0, br};
        if (!mode) adj_comp = sum[IMG_PIX_W] ? {IMG_PIX_W{1'b1}} : sum[IMG_PIX_W-1:0];
        else       adj_comp = dif[IMG_PIX_W] ? {IMG_PIX_W{1'b0}} : dif[IMG_PIX_W-1:0];
    endfunction

    assign w_ahb_sel   = sl_HSEL & sl_HREADY & sl_HTRANS[1];
    // Start from IDLE uses live WIDTH/HEIGHT; continuation from GAP uses live continuous bit.
    assign w_go_vsync  = ((r_state == ST_IDLE) && r_ctrl[0] && (r_width != '0) && (r_height != '0)) ||
                         ((r_state == ST_GAP) && (r_cnt == r_sh_gap) && r_ctrl[1]);
    assign w_col_next  = {1'b0, r_col} + (W_SIZE+1)'(N_PIX);
    assign w_line_end  = (w_col_next >= {1'b0, r_sh_width});
    assign w_last_row  = (r_row == (r_sh_height - W_SIZE'(1)));
    assign w_frame_end = (r_state == ST_DATA) && w_line_end && w_last_row;
    assign w_unused    = &{1'b0, sl_HTRANS[0], sl_HADDR[W_ADDR-1:6], sl_HADDR[1:0], sl_HWDATA[W_DATA-1:W_SIZE]};

    // AHB address-phase capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ahb_idx <= 4'd0;
            r_ahb_wr  <= 1'b0;
            r_ahb_rd  <= 1'b0;
        end else if (sl_HREADY) begin
            r_ahb_wr <= w_ahb_sel & sl_HWRITE;
            r_ahb_rd <= w_ahb_sel & ~sl_HWRITE;
            if (w_ahb_sel) r_ahb_idx <= sl_HADDR[5:2];
        end
    end

    // Register file, IRQ pending and frame counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_width     <= W_SIZE'(DEF_WIDTH);
            r_height    <= W_SIZE'(DEF_HEIGHT);
            r_vdly      <= W_DELAY'(3);
            r_hdly      <= W_DELAY'(160);
            r_gap       <= W_DELAY'(200);
            r_ctrl      <= 4'd0;
            r_br        <= '0;
            r_irq_pend  <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            if (r_ahb_wr) begin
                case (r_ahb_idx)
                    4'd0:    r_width  <= sl_HWDATA[W_SIZE-1:0];
                    4'd1:    r_height <= sl_HWDATA[W_SIZE-1:0];
                    4'd2:    r_vdly   <= sl_HWDATA[W_DELAY-1:0];
                    4'd3:    r_hdly   <= sl_HWDATA[W_DELAY-1:0];
                    4'd4:    r_gap    <= sl_HWDATA[W_DELAY-1:0];
                    4'd5:    r_ctrl   <= sl_HWDATA[3:0];
                    4'd6:    r_br     <= sl_HWDATA[IMG_PIX_W-1:0];
                    default: ;
                endcase
            end
            if (w_go_vsync) r_ctrl[0] <= 1'b0;
            // A set in the final DATA cycle outranks a simultaneous W1C.
            if (w_frame_end) begin
                r_irq_pend  <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (r_ahb_wr && (r_ahb_idx == 4'd7) && sl_HWDATA[1]) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

    // Frame timing FSM with shadow capture and frame-buffer address counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_fb_addr   <= '0;
            r_sh_width  <= W_SIZE'(DEF_WIDTH);
            r_sh_height <= W_SIZE'(DEF_HEIGHT);
            r_sh_vdly   <= W_DELAY'(3);
            r_sh_hdly   <= W_DELAY'(160);
            r_sh_gap    <= W_DELAY'(200);
            r_sh_mode   <= 1'b0;
            r_sh_br     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go_vsync) r_state <= ST_VSYNC;
                end
                ST_VSYNC: begin
                    if (r_cnt == r_sh_vdly) begin
                        r_cnt   <= '0;
                        r_state <= ST_HSYNC;
                    end else begin
                        r_cnt <= r_cnt + W_DELAY'(1);
                    end
                end
                ST_HSYNC: begin
                    if (r_cnt == r_sh_hdly) begin
                        r_cnt   <= '0;
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + W_DELAY'(1);
                    end
                end
                ST_DATA: begin
                    r_fb_addr <= r_fb_addr + W_FB_ADDR'(1);
                    if (w_line_end) begin
                        r_col <= '0;
                        if (w_last_row) begin
                            r_row   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_row   <= r_row + W_SIZE'(1);
                            r_state <= ST_HSYNC;
                        end
                    end else begin
                        r_col <= w_col_next[W_SIZE-1:0];
                    end
                end
                ST_GAP: begin
                    if (r_cnt == r_sh_gap) begin
                        r_cnt   <= '0;
                        r_state <= r_ctrl[1] ? ST_VSYNC : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + W_DELAY'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_go_vsync) begin
                r_cnt       <= '0;
                r_col       <= '0;
                r_row       <= '0;
                r_fb_addr   <= '0;
                r_sh_width  <= r_width;
                r_sh_height <= r_height;
                r_sh_vdly   <= r_vdly;
                r_sh_hdly   <= r_hdly;
                r_sh_gap    <= r_gap;
                r_sh_mode   <= r_ctrl[2];
                r_sh_br     <= r_br;
            end
        end
    end

    // Per-component brightness on the returning frame-buffer word
    always_comb begin
        w_adj = '0;
        for (int j = 0; j < N_COMP; j++) begin
            w_adj[j*IMG_PIX_W +: IMG_PIX_W] = adj_comp(IMG_PIX_W'(fb_rd_data[j*8 +: 8]), r_sh_mode, r_sh_br);
        end
    end

    // Output stage: sync/valid flags delayed twice to line up with registered pixel data
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_flags_d1 <= 3'd0;
            r_flags_d2 <= 3'd0;
            r_out_data <= '0;
        end else begin
            r_flags_d1 <= {r_state == ST_VSYNC, r_state == ST_HSYNC, r_state == ST_DATA};
            r_flags_d2 <= r_flags_d1;
            r_out_data <= w_adj;
        end
    end

    // Read data mux driven from the latched data-phase index
    always_comb begin
        w_rdata = '0;
        if (r_ahb_rd) begin
            case (r_ahb_idx)
                4'd0:    w_rdata = W_DATA'(r_width);
                4'd1:    w_rdata = W_DATA'(r_height);
                4'd2:    w_rdata = W_DATA'(r_vdly);
                4'd3:    w_rdata = W_DATA'(r_hdly);
                4'd4:    w_rdata = W_DATA'(r_gap);
                4'd5:    w_rdata = W_DATA'(r_ctrl);
                4'd6:    w_rdata = W_DATA'(r_br);
                4'd7:    w_rdata = W_DATA'({r_irq_pend, r_state != ST_IDLE});
                4'd8:    w_rdata = W_DATA'(r_frame_cnt);
                default: w_rdata = '0;
            endcase
        end else begin
            w_rdata = '0;
        end
    end

    assign out_sl_HREADY = 1'b1;
    assign out_sl_HRESP  = 2'b00;
    assign out_sl_HRDATA = w_rdata;
    assign fb_rd_en      = (r_state == ST_DATA);
    assign fb_rd_addr    = r_fb_addr;
    assign out_vsync     = r_flags_d2[2];
    assign out_hsync     = r_flags_d2[1];
    assign out_valid     = r_flags_d2[0];
    assign out_data      = r_out_data;
    assign out_irq       = r_irq_pend & r_ctrl[3];
endmodule

// File: tb/tb_lcd_drive_ctrl_mp.sv
// Self-checking bench for lcd_drive_ctrl_mp: register access, frame timing, brightness,
// continuous mode, IRQ and mid-frame reset, checked against a frame-level reference model.
module tb_lcd_drive_ctrl_mp;
    localparam int N_PIX = 2;
    localparam int DW    = N_PIX * 24;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          sl_HSEL = 1'b0, sl_HREADY = 1'b1, sl_HWRITE = 1'b0;
    logic [1:0]    sl_HTRANS = 2'b00;
    logic [31:0]   sl_HADDR = 32'd0, sl_HWDATA = 32'd0;
    logic          out_sl_HREADY;
    logic [1:0]    out_sl_HRESP;
    logic [31:0]   out_sl_HRDATA;
    logic          fb_rd_en;
    logic [19:0]   fb_rd_addr;
    logic [DW-1:0] fb_rd_data = '0;
    logic          out_vsync, out_hsync, out_valid, out_irq;
    logic [DW-1:0] out_data;

    lcd_drive_ctrl_mp dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY),
        .sl_HTRANS(sl_HTRANS), .sl_HADDR(sl_HADDR), .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_valid(out_valid),
        .out_data(out_data), .out_irq(out_irq)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int failures = 0;

    // Frame buffer memory with one-cycle read latency
    logic [DW-1:0] fb_mem [0:255];
    always @(posedge HCLK) begin
        if (fb_rd_en) fb_rd_data <= fb_mem[fb_rd_addr[7:0]];
    end

    // Passive monitor: records reads, output beats and frame starts
    int cyc = 0;
    int n_vs = 0;
    int n_hs = 0;
    logic prev_vs = 1'b0;
    int q_addr[$];
    int q_en_cyc[$];
    int q_val_cyc[$];
    int q_frame_start[$];
    logic [DW-1:0] q_out[$];
    always @(negedge HCLK) begin
        cyc     <= cyc + 1;
        n_vs    <= n_vs + int'(out_vsync);
        n_hs    <= n_hs + int'(out_hsync);
        prev_vs <= out_vsync;
        if (fb_rd_en) begin
            q_addr.push_back(int'(fb_rd_addr));
            q_en_cyc.push_back(cyc);
        end
        if (out_valid) begin
            q_out.push_back(out_data);
            q_val_cyc.push_back(cyc);
        end
        if (out_vsync && !prev_vs) q_frame_start.push_back(q_out.size());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: brightness applied to one frame-buffer word
    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w, input int mode, input int br);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < N_PIX * 3; j++) begin
            int c;
            int v;
            c = int'(w[j*8 +: 8]);
            v = (mode == 0) ? c + br : c - br;
            if (v > 255) v = 255;
            if (v < 0) v = 0;
            r[j*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    task automatic bus_wr_now(input int idx, input logic [31:0] d);
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = 32'(idx) << 2;
        @(negedge HCLK);
        sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic ahb_write(input int idx, input logic [31:0] d);
        @(negedge HCLK);
        bus_wr_now(idx, d);
    endtask

    task automatic ahb_read(input int idx, output logic [31:0] d);
        @(negedge HCLK);
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b0; sl_HADDR = 32'(idx) << 2;
        @(negedge HCLK);
        sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
        d = out_sl_HRDATA;
    endtask

    task automatic fill_fb();
        logic [63:0] t;
        for (int i = 0; i < 256; i++) begin
            t = {$urandom(), $urandom()};
            fb_mem[i] = t[DW-1:0];
        end
    endtask

    task automatic config_frame(input int w, input int h, input int vd, input int hd, input int gap, input int br);
        ahb_write(0, 32'(w));
        ahb_write(1, 32'(h));
        ahb_write(2, 32'(vd));
        ahb_write(3, 32'(hd));
        ahb_write(4, 32'(gap));
        ahb_write(6, 32'(br));
    endtask

    task automatic wait_idle(output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ahb_read(7, d);
            if (d[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge HCLK);
    endtask

    task automatic wait_frames(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge HCLK);
            if (q_frame_start.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int exp_rst [0:8];
        exp_rst = '{768, 512, 3, 160, 200, 0, 0, 0, 0};
        do_reset();
        @(negedge HCLK);
        checks++;
        if ({out_sl_HREADY, out_sl_HRESP, out_sl_HRDATA} !== {1'b1, 2'b00, 32'd0}) begin
            failures++; $display("FAIL reset_bus: got %b/%0d/%h want 1/0/0", out_sl_HREADY, out_sl_HRESP, out_sl_HRDATA);
        end
        checks++;
        if ({fb_rd_en, fb_rd_addr, out_vsync, out_hsync, out_valid, out_irq, out_data} !== '0) begin
            failures++; $display("FAIL reset_outputs: en=%b addr=%0d vs=%b hs=%b val=%b irq=%b data=%h want all 0",
                                 fb_rd_en, fb_rd_addr, out_vsync, out_hsync, out_valid, out_irq, out_data);
        end
        for (int i = 0; i < 9; i++) begin
            ahb_read(i, d);
            checks++;
            if (d !== 32'(exp_rst[i])) begin
                failures++; $display("FAIL reset_reg%0d: got %0d want %0d", i, d, exp_rst[i]);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        ahb_write(6, 32'hA5);
        ahb_read(6, d);
        checks++;
        if (d !== 32'hA5) begin failures++; $display("FAIL reg_br: got %h want a5", d); end
        ahb_write(12, 32'hFFFF_FFFF);
        ahb_read(12, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reg_unmapped: got %h want 0", d); end
        ahb_write(7, 32'h1);
        ahb_read(7, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reg_busy_ro: got %h want 0", d); end
        ahb_write(6, 32'h0);
    endtask

    task automatic test_frame_basic();
        logic [31:0] d;
        bit ok;
        int a0, v0, vs0, hs0;
        fill_fb();
        config_frame(8, 2, 2, 2, 2, 0);
        a0 = q_addr.size(); v0 = q_out.size(); vs0 = n_vs; hs0 = n_hs;
        ahb_write(5, 32'h1);
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout: busy never cleared"); end
        checks++;
        if (q_out.size() - v0 != 8 || q_addr.size() - a0 != 8) begin
            failures++; $display("FAIL basic_beats: got %0d beats %0d reads want 8/8", q_out.size() - v0, q_addr.size() - a0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q_addr[a0+i] !== i || q_out[v0+i] !== model_word(fb_mem[i], 0, 0)) begin
                    failures++; $display("FAIL basic_word%0d: addr %0d data %h want %0d %h", i, q_addr[a0+i], q_out[v0+i], i, fb_mem[i]);
                end
            end
            checks++;
            if (q_val_cyc[v0] - q_en_cyc[a0] != 2) begin
                failures++; $display("FAIL basic_latency: got %0d want 2", q_val_cyc[v0] - q_en_cyc[a0]);
            end
        end
        checks++;
        if (n_vs - vs0 != 3 || n_hs - hs0 != 6) begin
            failures++; $display("FAIL basic_sync: vs %0d hs %0d want 3/6", n_vs - vs0, n_hs - hs0);
        end
        ahb_read(8, d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL basic_frame_cnt: got %0d want 1", d); end
        ahb_read(5, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL basic_start_clear: got %h want 0", d); end
    endtask

    task automatic test_brightness();
        bit ok;
        int v0;
        int mode [0:5], br [0:5], comp [0:5], expv [0:5];
        logic [7:0] c8, e8;
        mode = '{0, 1, 1, 0, 0, 1};
        br   = '{100, 50, 50, 20, 100, 120};
        comp = '{200, 30, 120, 10, 155, 120};
        expv = '{255, 0, 70, 30, 255, 0};
        for (int k = 0; k < 6; k++) begin
            c8 = 8'(comp[k]); e8 = 8'(expv[k]);
            fb_mem[0] = {6{c8}};
            config_frame(2, 1, 0, 0, 0, br[k]);
            v0 = q_out.size();
            ahb_write(5, 32'(mode[k] << 2) | 32'h1);
            wait_idle(ok);
            checks++;
            if (q_out.size() - v0 != 1) begin
                failures++; $display("FAIL bright%0d_count: got %0d want 1", k, q_out.size() - v0);
            end else if (q_out[v0] !== {6{e8}}) begin
                failures++; $display("FAIL bright%0d: got %h want %h", k, q_out[v0], {6{e8}});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, fc0;
        bit ok;
        int w, h, vd, hd, gap, md, br, words, a0, v0, vs0, hs0;
        for (int it = 0; it < 6; it++) begin
            w = $urandom_range(1, 12); h = $urandom_range(1, 3);
            vd = $urandom_range(0, 3); hd = $urandom_range(0, 3); gap = $urandom_range(0, 3);
            md = $urandom_range(0, 1); br = $urandom_range(0, 255);
            words = ((w + N_PIX - 1) / N_PIX) * h;
            fill_fb();
            config_frame(w, h, vd, hd, gap, br);
            ahb_read(8, fc0);
            a0 = q_addr.size(); v0 = q_out.size(); vs0 = n_vs; hs0 = n_hs;
            ahb_write(5, 32'(md << 2) | 32'h1);
            wait_idle(ok);
            checks++;
            if (!ok || q_out.size() - v0 != words || q_addr.size() - a0 != words) begin
                failures++; $display("FAIL rand%0d_count: w=%0d h=%0d beats %0d reads %0d want %0d", it, w, h,
                                     q_out.size() - v0, q_addr.size() - a0, words);
            end else begin
                for (int i = 0; i < words; i++) begin
                    checks++;
                    if (q_addr[a0+i] !== i || q_out[v0+i] !== model_word(fb_mem[i], md, br)) begin
                        failures++; $display("FAIL rand%0d_word%0d: addr %0d data %h want %0d %h", it, i, q_addr[a0+i],
                                             q_out[v0+i], i, model_word(fb_mem[i], md, br));
                    end
                end
            end
            checks++;
            if (n_vs - vs0 != vd + 1 || n_hs - hs0 != h * (hd + 1)) begin
                failures++; $display("FAIL rand%0d_sync: vs %0d hs %0d want %0d/%0d", it, n_vs - vs0, n_hs - hs0, vd + 1, h * (hd + 1));
            end
            ahb_read(8, d);
            checks++;
            if (d !== fc0 + 32'd1) begin failures++; $display("FAIL rand%0d_frame_cnt: got %0d want %0d", it, d, fc0 + 1); end
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        bit ok;
        int a0;
        config_frame(4, 1, 2, 2, 2, 0);
        ahb_write(7, 32'h2);
        ahb_write(5, 32'h9);
        wait_idle(ok);
        checks++;
        if (out_irq !== 1'b1) begin failures++; $display("FAIL irq_rise: got %b want 1", out_irq); end
        ahb_read(7, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL irq_status: got %h want 2", d); end
        ahb_write(7, 32'h2);
        checks++;
        if (out_irq !== 1'b0) begin failures++; $display("FAIL irq_w1c: got %b want 0", out_irq); end
        ahb_write(5, 32'h9);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (fb_rd_en) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL irq_data_wait: no DATA cycle seen"); end
        bus_wr_now(7, 32'h2);
        wait_idle(ok);
        ahb_read(7, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL irq_set_wins: got %h want 2", d); end
        ahb_write(5, 32'h0);
        checks++;
        if (out_irq !== 1'b0) begin failures++; $display("FAIL irq_mask: got %b want 0", out_irq); end
        ahb_write(7, 32'h2);
        ahb_write(0, 32'h0);
        a0 = q_addr.size();
        ahb_write(5, 32'h1);
        repeat (10) @(negedge HCLK);
        ahb_read(7, d);
        checks++;
        if (d !== 32'h0 || q_addr.size() != a0) begin
            failures++; $display("FAIL irq_width0_idle: status %h reads %0d want 0/0", d, q_addr.size() - a0);
        end
        ahb_write(5, 32'h0);
        ahb_write(0, 32'd4);
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        bit ok;
        int f0, b [0:2];
        do_reset();
        fill_fb();
        config_frame(4, 1, 8, 4, 3, 0);
        f0 = q_frame_start.size();
        ahb_write(5, 32'h3);
        wait_frames(f0 + 2, ok);
        ahb_read(8, d);
        checks++;
        if (!ok || d !== 32'd1) begin failures++; $display("FAIL cont_cnt1: got %0d want 1 (ok=%0d)", d, ok); end
        ahb_read(5, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL cont_start_clear: got %h want 2", d); end
        ahb_write(0, 32'd8);
        wait_frames(f0 + 3, ok);
        ahb_read(8, d);
        checks++;
        if (!ok || d !== 32'd2) begin failures++; $display("FAIL cont_cnt2: got %0d want 2 (ok=%0d)", d, ok); end
        ahb_write(5, 32'h0);
        wait_idle(ok);
        repeat (30) @(negedge HCLK);
        checks++;
        if (!ok || q_frame_start.size() - f0 != 3) begin
            failures++; $display("FAIL cont_stop: got %0d frames want 3", q_frame_start.size() - f0);
        end else begin
            b[0] = q_frame_start[f0+1] - q_frame_start[f0];
            b[1] = q_frame_start[f0+2] - q_frame_start[f0+1];
            b[2] = q_out.size() - q_frame_start[f0+2];
            checks++;
            if (b[0] != 2 || b[1] != 2 || b[2] != 4) begin
                failures++; $display("FAIL cont_shadow: beats %0d,%0d,%0d want 2,2,4", b[0], b[1], b[2]);
            end
        end
        ahb_read(8, d);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL cont_cnt3: got %0d want 3", d); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int a0, v0, ar;
        fill_fb();
        config_frame(8, 4, 1, 1, 1, 0);
        ahb_write(5, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (fb_rd_en) begin ok = 1'b1; break; end
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (!ok || {fb_rd_en, fb_rd_addr, out_vsync, out_hsync, out_valid, out_irq, out_data, out_sl_HRDATA} !== '0) begin
            failures++; $display("FAIL midreset_outputs: en=%b addr=%0d val=%b data=%h (ok=%0d) want all 0",
                                 fb_rd_en, fb_rd_addr, out_valid, out_data, ok);
        end
        ar = q_addr.size();
        repeat (3) @(negedge HCLK);
        checks++;
        if (q_addr.size() != ar) begin failures++; $display("FAIL midreset_no_reads: got %0d want 0", q_addr.size() - ar); end
        HRESETn = 1'b1;
        config_frame(4, 1, 1, 1, 1, 0);
        a0 = q_addr.size(); v0 = q_out.size();
        ahb_write(5, 32'h1);
        wait_idle(ok);
        checks++;
        if (!ok || q_addr.size() - a0 != 2 || q_out.size() - v0 != 2) begin
            failures++; $display("FAIL midreset_restart_count: reads %0d beats %0d want 2/2", q_addr.size() - a0, q_out.size() - v0);
        end else begin
            checks++;
            if (q_addr[a0] !== 0 || q_addr[a0+1] !== 1 || q_out[v0] !== fb_mem[0] || q_out[v0+1] !== fb_mem[1]) begin
                failures++; $display("FAIL midreset_restart: addrs %0d,%0d data %h,%h want 0,1 %h,%h",
                                     q_addr[a0], q_addr[a0+1], q_out[v0], q_out[v0+1], fb_mem[0], fb_mem[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_frame_basic();
        test_brightness();
        test_random();
        test_irq();
        test_continuous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
